// File: rtl/bnn_cmd_encoder_if.sv
// Request, payload and output byte-stream signals of the BNN command encoder.
// Handshake rule for all three channels: a transfer happens on the rising edge where valid && ready are both high.
interface bnn_cmd_encoder_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_len;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output req_valid, req_op, req_len, pl_valid, pl_data, tx_ready,
        input  req_ready, pl_ready, tx_valid, tx_data
    );

    modport slave (
        input  req_valid, req_op, req_len, pl_valid, pl_data, tx_ready,
        output req_ready, pl_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/bnn_cmd_encoder.sv
// Frames BNN write commands as opcode, length, payload bytes and trailer into a
// single registered byte stream.
module bnn_cmd_encoder #(
    parameter logic [7:0] TRAILER    = 8'hAE,
    parameter logic [7:0] OPC_INPUT  = 8'hB1,
    parameter logic [7:0] OPC_WEIGHT = 8'hB2,
    parameter logic [7:0] OPC_BIAS   = 8'hB3
) (
    input  logic                    clk,
    input  logic                    rst,
    bnn_cmd_encoder_if.slave        bus,
    output logic                    busy,
    output logic                    err,
    output logic [15:0]             frame_cnt,
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPC     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        TRAIL   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [7:0]  len_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        tx_last_q;
    logic        err_q;
    logic [15:0] frame_cnt_q;

    logic        slot_free;
    logic        req_hs;
    logic        pl_hs;
    logic        load;
    logic        load_last;
    logic [7:0]  load_byte;

    function automatic logic [7:0] opcode_of(input logic [1:0] op);
        logic [7:0] code;
        case (op)
            2'd0:    code = OPC_INPUT;
            2'd1:    code = OPC_WEIGHT;
            default: code = OPC_BIAS;
        endcase
        return code;
    endfunction

    assign slot_free     = !tx_valid_q || bus.tx_ready;
    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign req_hs        = bus.req_valid && bus.req_ready;
    assign bus.pl_ready  = (state_q == PAYLOAD) && slot_free && !rst;
    assign pl_hs         = bus.pl_valid && bus.pl_ready;

    // The opcode loads on the handshake edge itself when the slot is free; OPC
    // only waits out a trailer that is still stalled downstream.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_last = 1'b0;
        load_byte = tx_data_q;
        case (state_q)
            IDLE: begin
                if (req_hs && (bus.req_op != 2'd3)) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_byte = opcode_of(bus.req_op);
                        state_d   = LEN;
                    end else begin
                        state_d   = OPC;
                    end
                end
            end
            OPC: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = opcode_of(op_q);
                    state_d   = LEN;
                end
            end
            LEN: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = len_q;
                    cnt_d     = len_q;
                    state_d   = (len_q == 8'd0) ? TRAIL : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (pl_hs) begin
                    load      = 1'b1;
                    load_byte = bus.pl_data;
                    cnt_d     = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = TRAILER;
                    load_last = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx_last_q marks the trailer so payload bytes equal to TRAILER never count a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 2'd0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= req_hs && (bus.req_op == 2'd3);
            if (req_hs) begin
                op_q  <= bus.req_op;
                len_q <= bus.req_len;
            end
            if (slot_free) begin
                tx_valid_q <= load;
                tx_last_q  <= load_last;
                if (load) begin
                    tx_data_q <= load_byte;
                end
            end
            if (tx_valid_q && bus.tx_ready && tx_last_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign busy         = (state_q != IDLE);
    assign err          = err_q;
    assign frame_cnt    = frame_cnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_bnn_cmd_encoder.sv
// Bench for bnn_cmd_encoder: directed frames with literal expectations plus
// randomized frames checked against a frame-level byte-queue model.
module tb_bnn_cmd_encoder;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        err;
    logic [15:0] frame_cnt;
    logic [2:0]  state_dbg;

    bnn_cmd_encoder_if ifc ();

    bnn_cmd_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc),
        .busy      (busy),
        .err       (err),
        .frame_cnt (frame_cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    bit          last_q[$];
    logic [7:0]  log_q[$];
    int          log_cyc[$];
    logic [7:0]  tail[$];
    bit          err_exp[int];
    logic [15:0] model_cnt = 16'd0;
    int          pl_pending = 0;
    int          xfers = 0;
    bit          pl_seen = 1'b0;
    bit          abort = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          hold_prev = 1'b0;
    logic [7:0]  hold_data = 8'h00;
    logic [7:0]  pl_buf [256];
    logic [7:0]  opc_tab [3] = '{8'hB1, 8'hB2, 8'hB3};
    logic [7:0]  special [4] = '{8'hAE, 8'hB1, 8'hB2, 8'hB3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_tail(input string name);
        int n;
        int m;
        n = log_q.size();
        m = tail.size();
        if (n < m) begin
            check({name, "_count"}, 32'(n), 32'(m));
            return;
        end
        for (int i = 0; i < m; i++) check(name, 32'(log_q[n-m+i]), 32'(tail[i]));
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [7:0] exp_b;
        bit         is_last;
        if (ifc.pl_ready) pl_seen = 1'b1;
        if (rst) begin
            exp_q.delete();
            last_q.delete();
            hold_prev = 1'b0;
            model_cnt = 16'd0;
        end else begin
            check("frame_cnt", 32'(frame_cnt), 32'(model_cnt));
            check("err", 32'(err), 32'(err_exp.exists(cyc)));
            if (hold_prev) begin
                check("hold_valid", 32'(ifc.tx_valid), 32'd1);
                check("hold_data", 32'(ifc.tx_data), 32'(hold_data));
            end
            if (pl_pending == 0) check("pl_ready_no_payload", 32'(ifc.pl_ready), 32'd0);
            if (ifc.tx_valid && ifc.tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(ifc.tx_data), 32'hFFFF_FFFF);
                end else begin
                    exp_b   = exp_q.pop_front();
                    is_last = last_q.pop_front();
                    check("tx_data", 32'(ifc.tx_data), 32'(exp_b));
                    if (is_last) model_cnt = model_cnt + 16'd1;
                end
                log_q.push_back(ifc.tx_data);
                log_cyc.push_back(cyc);
                xfers++;
            end
            hold_prev = ifc.tx_valid && !ifc.tx_ready;
            hold_data = ifc.tx_data;
        end
    end

    // ---------------- driver tasks ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) ifc.tx_ready = ($urandom_range(0, 9) < 7);
        end
    end

    // Called at posedge+1; returns at posedge+1 once the frame's payload is handed over.
    task automatic send_frame(input logic [1:0] op, input logic [7:0] len, input int gap_pct);
        int g;
        ifc.pl_valid  = 1'b0;
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_len   = len;
        g = 0;
        forever begin
            @(negedge clk);
            if (abort) begin
                ifc.req_valid = 1'b0;
                return;
            end
            if (ifc.req_ready) break;
            g++;
            if (g > 300) begin
                check("req_timeout", 32'd0, 32'd1);
                ifc.req_valid = 1'b0;
                return;
            end
        end
        if (op == 2'd3) begin
            err_exp[cyc + 1] = 1'b1;
        end else begin
            exp_q.push_back(opc_tab[op]);
            last_q.push_back(1'b0);
            exp_q.push_back(len);
            last_q.push_back(1'b0);
            for (int i = 0; i < int'(len); i++) begin
                exp_q.push_back(pl_buf[i]);
                last_q.push_back(1'b0);
            end
            exp_q.push_back(8'hAE);
            last_q.push_back(1'b1);
            pl_pending = int'(len);
        end
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        ifc.req_op    = 2'($urandom);
        ifc.req_len   = 8'($urandom);
        for (int i = 0; i < int'(len) && op != 2'd3; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                ifc.pl_valid = 1'b0;
                ifc.pl_data  = 8'($urandom);
                @(posedge clk);
                #1;
                if (abort) begin
                    pl_pending = 0;
                    return;
                end
            end
            ifc.pl_valid = 1'b1;
            ifc.pl_data  = pl_buf[i];
            g = 0;
            forever begin
                @(negedge clk);
                if (abort) begin
                    ifc.pl_valid = 1'b0;
                    pl_pending   = 0;
                    return;
                end
                if (ifc.pl_ready) break;
                g++;
                if (g > 300) begin
                    check("pl_timeout", 32'd0, 32'd1);
                    ifc.pl_valid = 1'b0;
                    pl_pending   = 0;
                    return;
                end
            end
            @(posedge clk);
            #1;
            pl_pending--;
        end
        // Junk offered after the last byte: the encoder must not take it.
        ifc.pl_valid = 1'($urandom_range(0, 1));
        ifc.pl_data  = 8'($urandom);
    endtask

    task automatic drain();
        int g;
        g = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !ifc.tx_valid) break;
            g++;
            if (g > 3000) begin
                check("drain_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int errs;
        bit txv;
        bit bsy;
        int g;
        logic [1:0] op;
        logic [7:0] len;

        rst           = 1'b1;
        ifc.req_valid = 1'b0;
        ifc.req_op    = 2'd0;
        ifc.req_len   = 8'd0;
        ifc.pl_valid  = 1'b0;
        ifc.pl_data   = 8'd0;
        ifc.tx_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(ifc.req_ready), 32'd0);
        check("rst_tx_valid", 32'(ifc.tx_valid), 32'd0);
        check("rst_tx_data", 32'(ifc.tx_data), 32'h00);
        check("rst_pl_ready", 32'(ifc.pl_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_req_ready", 32'(ifc.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // op=1 len=2 with a free-running sink: five bytes back to back
        ifc.tx_ready = 1'b1;
        pl_buf[0] = 8'hDE;
        pl_buf[1] = 8'h00;
        send_frame(2'd1, 8'd2, 0);
        drain();
        tail = '{8'hB2, 8'h02, 8'hDE, 8'h00, 8'hAE};
        check_tail("weight_frame");
        check("no_bubble", 32'(log_cyc[log_cyc.size()-1] - log_cyc[log_cyc.size()-5]), 32'd4);
        @(negedge clk);
        check("weight_frame_cnt", 32'(frame_cnt), 32'd1);
        @(posedge clk);
        #1;

        // op=2 len=0: no payload phase at all
        pl_seen = 1'b0;
        send_frame(2'd2, 8'd0, 0);
        drain();
        tail = '{8'hB3, 8'h00, 8'hAE};
        check_tail("bias_empty");
        check("bias_empty_pl_ready", 32'(pl_seen), 32'd0);

        // op=0 len=3 with the sink stalled for four cycles on the opcode
        ifc.tx_ready = 1'b0;
        pl_buf[0] = 8'hAE;
        pl_buf[1] = 8'hB1;
        pl_buf[2] = 8'h5A;
        fork
            send_frame(2'd0, 8'd3, 0);
            begin
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!ifc.tx_valid && g < 50);
                check("stall_valid", 32'(ifc.tx_valid), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (i > 0) @(negedge clk);
                    check("stall_data", 32'(ifc.tx_data), 32'hB1);
                end
                @(posedge clk);
                #1;
                ifc.tx_ready = 1'b1;
            end
        join
        drain();
        tail = '{8'hB1, 8'h03, 8'hAE, 8'hB1, 8'h5A, 8'hAE};
        check_tail("stall_frame");

        // illegal opcode, then a legal frame
        errs = 0;
        txv  = 1'b0;
        bsy  = 1'b0;
        fork
            send_frame(2'd3, 8'd9, 0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    errs += int'(err);
                    txv |= ifc.tx_valid;
                    bsy |= busy;
                end
            end
        join
        check("illegal_err_cycles", 32'(errs), 32'd1);
        check("illegal_tx_valid", 32'(txv), 32'd0);
        check("illegal_busy", 32'(bsy), 32'd0);
        @(negedge clk);
        check("illegal_frame_cnt", 32'(frame_cnt), 32'd3);
        @(posedge clk);
        #1;
        pl_buf[0] = 8'h77;
        send_frame(2'd0, 8'd1, 0);
        drain();
        tail = '{8'hB1, 8'h01, 8'h77, 8'hAE};
        check_tail("after_illegal");
        @(negedge clk);
        check("after_illegal_cnt", 32'(frame_cnt), 32'd4);
        @(posedge clk);
        #1;

        // reset while the second payload byte of a len=4 frame is in flight
        for (int i = 0; i < 4; i++) pl_buf[i] = 8'(8'h10 + i);
        xfers = 0;
        fork
            send_frame(2'd1, 8'd4, 0);
            begin
                g = 0;
                while (xfers < 3 && g < 100) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                check("mid_reset_reached", 32'(xfers >= 3), 32'd1);
                rst   = 1'b1;
                abort = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("mid_rst_tx_valid", 32'(ifc.tx_valid), 32'd0);
                check("mid_rst_tx_data", 32'(ifc.tx_data), 32'h00);
                check("mid_rst_pl_ready", 32'(ifc.pl_ready), 32'd0);
                check("mid_rst_busy", 32'(busy), 32'd0);
                check("mid_rst_err", 32'(err), 32'd0);
                check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
                check("mid_rst_req_ready", 32'(ifc.req_ready), 32'd1);
            end
        join
        abort = 1'b0;
        txv = 1'b0;
        repeat (3) begin
            @(negedge clk);
            txv |= ifc.tx_valid;
        end
        check("no_trailer_after_reset", 32'(txv), 32'd0);
        @(posedge clk);
        #1;
        pl_buf[0] = 8'hAE;
        send_frame(2'd0, 8'd1, 0);
        drain();
        tail = '{8'hB1, 8'h01, 8'hAE, 8'hAE};
        check_tail("post_reset_frame");
        @(negedge clk);
        check("post_reset_cnt", 32'(frame_cnt), 32'd1);
        @(posedge clk);
        #1;

        // randomized frames with a random sink and payload gaps
        rand_rdy = 1'b1;
        for (int f = 0; f < 70; f++) begin
            op  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            len = (f == 20) ? 8'd255 : (f == 40) ? 8'd1 : 8'($urandom_range(0, 9));
            for (int i = 0; i < 256; i++)
                pl_buf[i] = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : 8'($urandom);
            send_frame(op, len, 20);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        ifc.tx_ready = 1'b1;

        // frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        model_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_cnt_q;
        @(negedge clk);
        check("preload_cnt", 32'(frame_cnt), 32'hFFFF);
        @(posedge clk);
        #1;
        send_frame(2'd2, 8'd0, 0);
        drain();
        tail = '{8'hB3, 8'h00, 8'hAE};
        check_tail("wrap_frame");
        @(negedge clk);
        check("wrap_cnt", 32'(frame_cnt), 32'h0000);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        check("watchdog", 32'd0, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bnn_cmd_encoder.md
BNN_CMD_ENCODER -- requirements
Module: bnn_cmd_encoder

Interface
REQ-001 Parameter: TRAILER, 8'hAE, end-of-frame byte.
REQ-002 Parameter: OPC_INPUT, 8'hB1, opcode for input writes.
REQ-003 Parameter: OPC_WEIGHT, 8'hB2, opcode for weight writes.
REQ-004 Parameter: OPC_BIAS, 8'hB3, opcode for bias writes.
REQ-005 Port: clk  in  1  clock; single clock domain, all logic on rising edge.
REQ-006 Port: rst  in  1  reset; synchronous, active-high.
REQ-007 Port: req_valid  in  1  frame request present.
REQ-008 Port: req_ready  out  1  encoder accepts request.
REQ-009 Port: req_op  in  2  0=input, 1=weight, 2=bias, 3=illegal.
REQ-010 Port: req_len  in  8  payload byte count, 0..255.
REQ-011 Port: pl_valid  in  1  payload byte present.
REQ-012 Port: pl_data  in  8  payload byte.
REQ-013 Port: pl_ready  out  1  payload byte consumed.
REQ-014 Port: tx_valid  out  1  output byte present.
REQ-015 Port: tx_data  out  8  output byte toward decoder/SPI shifter.
REQ-016 Port: tx_ready  in  1  downstream accepts byte.
REQ-017 Port: busy  out  1  high whenever state is not IDLE.
REQ-018 Port: err  out  1  one-cycle pulse on illegal opcode.
REQ-019 Port: frame_cnt  out  16  completed frames, wraps 16'hFFFF->0.

Function
REQ-020 Frame format, in order: opcode byte, length byte (req_len), req_len payload bytes, TRAILER.
REQ-021 FSM states: IDLE, OPC, LEN, PAYLOAD, TRAIL.
REQ-022 req_ready is high only in IDLE; handshake = req_valid && req_ready; req_op and req_len are latched on the handshake.
REQ-023 Legal op: IDLE->OPC; opcode on tx_data with tx_valid high on the cycle after the handshake (1-cycle latency).
REQ-024 Illegal op (3): err pulses high on the cycle after the handshake, no byte is emitted, and the FSM stays in IDLE.
REQ-025 Output slot free = !tx_valid || tx_ready; each byte loads into the tx_data/tx_valid register only when the slot is free.
REQ-026 While tx_valid && !tx_ready, tx_data and tx_valid are held stable.
REQ-027 State transitions: OPC->LEN on opcode load; LEN->PAYLOAD on length load if len!=0, else LEN->TRAIL; PAYLOAD->TRAIL when the last payload byte loads; TRAIL->IDLE when the trailer loads.
REQ-028 pl_ready = (state==PAYLOAD) && slot free; a byte transfers on pl_valid && pl_ready and loads into tx_data the same edge.
REQ-029 Payload counter loads req_len and decrements per transfer; exactly req_len bytes are taken, never more.
REQ-030 pl_valid low in PAYLOAD: tx_valid drops after the current byte is accepted, the state holds, and there is no timeout.
REQ-031 No bubbles: with tx_ready and pl_valid held high, one byte is emitted per cycle; frame length = req_len+3 cycles.
REQ-032 frame_cnt increments on the cycle the trailer is accepted downstream (tx_valid && tx_ready with the trailer).
REQ-033 A new request is accepted on the cycle after the FSM returns to IDLE, even while the trailer is still awaiting tx_ready; tx_valid remains correct in that case.
REQ-034 Payload bytes equal to TRAILER or an opcode value are passed through unmodified (no escaping).

Reset
REQ-035 rst high on any edge: state=IDLE, tx_valid=0, tx_data=8'h00, pl_ready=0, err=0, busy=0, frame_cnt=0, payload counter=0.
REQ-036 Reset mid-frame aborts the frame with no trailer; the partial frame is not counted.
REQ-037 req_ready=0 while rst is high; the first request is accepted on the first cycle after rst falls.

Verification
REQ-038 op=1, len=2, payload DE,00, tx_ready=1 -> tx_data B2,02,DE,00,AE on consecutive cycles; frame_cnt=1.
REQ-039 op=2, len=0 -> B3,00,AE; pl_ready never asserted.
REQ-040 op=0, len=3, tx_ready low for 4 cycles after the opcode -> B1 held stable throughout; the stream continues correctly once tx_ready rises.
REQ-041 op=3 -> err high for exactly 1 cycle; tx_valid stays 0; frame_cnt unchanged; next legal request accepted normally.
REQ-042 rst asserted during the 2nd payload byte of a len=4 frame -> all outputs at reset values next cycle; no AE emitted; a following op=0, len=1 frame is correct.
REQ-043 frame_cnt preloaded to FFFF via 65535 len=0 frames (or force) -> next frame wraps it to 0000.
